// File: rtl/uart_rx_packet_ctrl_if.sv
// Byte-stream bundle between the RS-232 byte receiver, the packet sequencer and the downstream consumer.
interface uart_rx_packet_ctrl_if;
    logic       rx_data_ready;
    logic [7:0] rx_data;
    logic       rx_endofpacket;
    logic       pkt_valid;
    logic [7:0] pkt_data;
    logic       pkt_last;
    logic       pkt_ready;
    logic [7:0] pkt_len;

    modport slave (
        input  rx_data_ready, rx_data, rx_endofpacket, pkt_ready,
        output pkt_valid, pkt_data, pkt_last, pkt_len
    );

    modport master (
        output rx_data_ready, rx_data, rx_endofpacket, pkt_ready,
        input  pkt_valid, pkt_data, pkt_last, pkt_len
    );
endinterface

// File: rtl/uart_rx_packet_ctrl.sv
// Frames SYNC/LEN/payload/CSUM bytes, buffers the payload and releases only checksum-good packets.
// pkt_valid rises the cycle after the CSUM byte; output holds while pkt_ready is low, no bubbles otherwise.
module uart_rx_packet_ctrl #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_LEN   = 16,
    parameter int         CNT_W     = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    uart_rx_packet_ctrl_if.slave bus,
    output logic                 busy_o,
    output logic [CNT_W-1:0]     err_csum_cnt_o,
    output logic [CNT_W-1:0]     err_abort_cnt_o,
    output logic [CNT_W-1:0]     err_ovr_cnt_o
);
    localparam int               PTR_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_DRAIN
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       sum_q, sum_d;
    logic [7:0]       pkt_len_q, pkt_len_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] csum_cnt_q, csum_cnt_d;
    logic [CNT_W-1:0] abort_cnt_q, abort_cnt_d;
    logic [CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;
    logic [7:0]       mem_q [MAX_LEN];

    logic       mem_we;
    logic       rx_byte;
    logic       rx_eop;
    logic       drain_xfer;
    logic       rd_last;
    logic       wr_last;
    logic [7:0] csum_total;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign rx_byte    = bus.rx_data_ready;
    assign rx_eop     = bus.rx_endofpacket;
    assign drain_xfer = (state_q == ST_DRAIN) && bus.pkt_ready;
    assign rd_last    = (8'(rd_ptr_q) == (pkt_len_q - 8'd1));
    assign wr_last    = (8'(wr_ptr_q) == (len_q - 8'd1));
    assign csum_total = sum_q + bus.rx_data;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        sum_d       = sum_q;
        pkt_len_d   = pkt_len_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        csum_cnt_d  = csum_cnt_q;
        abort_cnt_d = abort_cnt_q;
        ovr_cnt_d   = ovr_cnt_q;
        mem_we      = 1'b0;

        // An idle gap inside a frame takes priority over a byte in the same cycle.
        case (state_q)
            ST_IDLE: begin
                if (rx_byte && (bus.rx_data == SYNC_BYTE)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_eop) begin
                    state_d     = ST_IDLE;
                    abort_cnt_d = sat_inc(abort_cnt_q);
                end else if (rx_byte) begin
                    if ((bus.rx_data == 8'd0) || (bus.rx_data > MAX_LEN_B)) begin
                        state_d     = ST_IDLE;
                        abort_cnt_d = sat_inc(abort_cnt_q);
                    end else begin
                        len_d    = bus.rx_data;
                        sum_d    = bus.rx_data;
                        wr_ptr_d = '0;
                        state_d  = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_eop) begin
                    state_d     = ST_IDLE;
                    abort_cnt_d = sat_inc(abort_cnt_q);
                end else if (rx_byte) begin
                    mem_we = 1'b1;
                    sum_d  = sum_q + bus.rx_data;
                    if (wr_last) begin
                        state_d = ST_CSUM;
                    end else begin
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end
                end
            end
            ST_CSUM: begin
                if (rx_eop) begin
                    state_d     = ST_IDLE;
                    abort_cnt_d = sat_inc(abort_cnt_q);
                end else if (rx_byte) begin
                    if (csum_total == 8'd0) begin
                        pkt_len_d = len_q;
                        rd_ptr_d  = '0;
                        state_d   = ST_DRAIN;
                    end else begin
                        state_d    = ST_IDLE;
                        csum_cnt_d = sat_inc(csum_cnt_q);
                    end
                end
            end
            ST_DRAIN: begin
                if (rx_byte) begin
                    ovr_cnt_d = sat_inc(ovr_cnt_q);
                end
                if (drain_xfer) begin
                    if (rd_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            sum_q       <= '0;
            pkt_len_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            csum_cnt_q  <= '0;
            abort_cnt_q <= '0;
            ovr_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            pkt_len_q   <= pkt_len_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            csum_cnt_q  <= csum_cnt_d;
            abort_cnt_q <= abort_cnt_d;
            ovr_cnt_q   <= ovr_cnt_d;
        end
    end

    // Payload storage needs no reset; nothing is read until a full frame has been written.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= bus.rx_data;
        end
    end

    assign bus.pkt_valid   = (state_q == ST_DRAIN);
    assign bus.pkt_data    = (state_q == ST_DRAIN) ? mem_q[rd_ptr_q] : 8'h00;
    assign bus.pkt_last    = (state_q == ST_DRAIN) && rd_last;
    assign bus.pkt_len     = pkt_len_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign err_csum_cnt_o  = csum_cnt_q;
    assign err_abort_cnt_o = abort_cnt_q;
    assign err_ovr_cnt_o   = ovr_cnt_q;
endmodule
